// File: rtl/sample_frame_capture.sv
// Multi-channel sample-frame capture: channel select, strobe decimation,
// ping-pong frame buffer and valid/ack handoff to the FFT.
`timescale 1ns/1ps
module sample_frame_capture #(
  parameter int unsigned POINTS     = 64,
  parameter int unsigned WIDTH      = 12,
  parameter int unsigned CHANNELS   = 8,
  parameter int unsigned SAMPLE_DIV = 3150
) (
  input  logic                                             clock,
  input  logic                                             reset,
  input  logic [CHANNELS*WIDTH-1:0]                        ch_data,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] ch_sel,
  input  logic [1:0]                                       mode,
  input  logic [WIDTH-1:0]                                 trig_level,
  input  logic                                             arm,
  input  logic                                             frame_ack,
  output logic [POINTS*WIDTH-1:0]                          frame_data,
  output logic                                             frame_valid,
  output logic                                             capturing,
  output logic                                             overrun
);

  localparam int unsigned SW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned IW = $clog2(POINTS);
  localparam int unsigned DW = $clog2(SAMPLE_DIV);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TRIG = 2'd1,
    FILL      = 2'd2
  } state_t;

  state_t                              state, state_next;
  logic   [DW-1:0]                     div;
  logic                                tick;
  logic   [IW-1:0]                     idx;
  logic   [SW-1:0]                     ch_lat, sel_map;
  logic   [1:0]                        mode_lat, mode_map;
  logic   [WIDTH-1:0]                  cur, prev;
  logic                                prev_valid;
  logic   [1:0][POINTS*WIDTH-1:0]      bank;
  logic                                rd_bank, wr_bank;
  logic                                trig_hit, complete, latch;
  logic                                swap, drop;

  assign tick     = (div == DW'(SAMPLE_DIV - 1));
  assign wr_bank  = ~rd_bank;
  assign cur      = ch_data[ch_lat*WIDTH +: WIDTH];
  assign sel_map  = (32'(ch_sel) >= CHANNELS) ? '0 : ch_sel;
  assign mode_map = (mode == 2'd3) ? 2'd0 : mode;

  assign trig_hit = (state == WAIT_TRIG) && tick && prev_valid &&
                    (prev < trig_level) && (cur >= trig_level);
  assign complete = (state == FILL) && tick && (idx == IW'(POINTS - 1));
  assign swap     = complete && (!frame_valid || frame_ack);
  assign drop     = complete && frame_valid && !frame_ack;
  assign latch    = ((state == IDLE) && (state_next != IDLE)) || complete;

  assign frame_data = bank[rd_bank];
  assign capturing  = (state == FILL);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div <= '0;
    end else if (tick) begin
      div <= '0;
    end else begin
      div <= div + DW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        case (mode_map)
          2'd1:    state_next = WAIT_TRIG;
          2'd2:    if (arm) state_next = FILL;
          default: state_next = FILL;
        endcase
      end
      WAIT_TRIG: if (trig_hit) state_next = FILL;
      FILL: begin
        // Follow-on state uses the mode of the frame just finished.
        if (complete) begin
          case (mode_lat)
            2'd1:    state_next = WAIT_TRIG;
            2'd2:    state_next = IDLE;
            default: state_next = FILL;
          endcase
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx         <= '0;
      ch_lat      <= '0;
      mode_lat    <= '0;
      prev        <= '0;
      prev_valid  <= 1'b0;
      bank        <= '0;
      rd_bank     <= 1'b0;
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (latch) begin
        ch_lat   <= sel_map;
        mode_lat <= mode_map;
      end

      // prev_valid drops outside WAIT_TRIG so the first tick after entry never fires.
      if (state != WAIT_TRIG) begin
        prev_valid <= 1'b0;
      end else if (tick) begin
        prev       <= cur;
        prev_valid <= 1'b1;
      end

      if (trig_hit) begin
        bank[wr_bank][0 +: WIDTH] <= cur;
        idx                       <= IW'(1);
      end else if ((state == FILL) && tick) begin
        bank[wr_bank][idx*WIDTH +: WIDTH] <= cur;
        idx                               <= complete ? '0 : idx + IW'(1);
      end else if (state == IDLE) begin
        idx <= '0;
      end

      if (swap) begin
        rd_bank     <= ~rd_bank;
        frame_valid <= 1'b1;
      end else if (frame_ack && frame_valid) begin
        frame_valid <= 1'b0;
      end

      if (drop) begin
        overrun <= 1'b1;
      end else if (frame_ack && frame_valid) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sample_frame_capture.sv
// Directed self-checking bench for sample_frame_capture (POINTS=8, SAMPLE_DIV=4).
`timescale 1ns/1ps
module tb_sample_frame_capture;

  localparam int unsigned P  = 8;
  localparam int unsigned W  = 12;
  localparam int unsigned C  = 4;
  localparam int unsigned SD = 4;
  localparam int unsigned FW = P * W;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [C*W-1:0] ch_data = '0;
  logic [1:0]    ch_sel = '0;
  logic [1:0]    mode = '0;
  logic [W-1:0]  trig_level = '0;
  logic          arm = 1'b0;
  logic          frame_ack = 1'b0;
  logic [FW-1:0] frame_data;
  logic          frame_valid;
  logic          capturing;
  logic          overrun;

  int errors = 0;
  int checks = 0;
  int sel_ch = 0;
  logic [FW-1:0] exp_frame;

  sample_frame_capture #(
    .POINTS(P), .WIDTH(W), .CHANNELS(C), .SAMPLE_DIV(SD)
  ) dut (
    .clock(clock), .reset(reset), .ch_data(ch_data), .ch_sel(ch_sel),
    .mode(mode), .trig_level(trig_level), .arm(arm), .frame_ack(frame_ack),
    .frame_data(frame_data), .frame_valid(frame_valid),
    .capturing(capturing), .overrun(overrun)
  );

  always #5 clock = ~clock;

  function automatic logic [FW-1:0] ramp(input int base);
    logic [FW-1:0] r;
    r = '0;
    for (int n = 0; n < P; n++) r[n*W +: W] = W'(base + n);
    return r;
  endfunction

  // One strobe period (SD clocks); v lands on the selected channel, the
  // others carry ~v. ackm: 1 = ack on first edge, 2 = ack on the tick edge.
  task automatic tk(input int v, input int ackm, input logic a);
    for (int k = 0; k < C; k++) ch_data[k*W +: W] = (k == sel_ch) ? W'(v) : ~W'(v);
    arm = a;
    frame_ack = (ackm == 1);
    @(posedge clock); #1;
    arm = 1'b0;
    frame_ack = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    frame_ack = (ackm == 2);
    @(posedge clock); #1;
    frame_ack = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock) reset = 1'b0;
    @(negedge clock) reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #22;
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", frame_valid); end
    checks++; if (capturing !== 1'b0) begin errors++; $display("FAIL reset_capturing: got %b expected 0", capturing); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    checks++; if (frame_data !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", frame_data); end
  endtask

  task automatic test_free_run();
    mode = 2'd0; ch_sel = 2'd2; sel_ch = 2;
    do_reset();
    for (int i = 0; i < 7; i++) tk(i, 0, 1'b0);
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL fr_valid_early: got %b expected 0", frame_valid); end
    checks++; if (capturing !== 1'b1) begin errors++; $display("FAIL fr_capturing: got %b expected 1", capturing); end
    tk(7, 0, 1'b0);
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL fr_valid: got %b expected 1", frame_valid); end
    exp_frame = ramp(0);
    checks++; if (frame_data !== exp_frame) begin errors++; $display("FAIL fr_frame0: got %h expected %h", frame_data, exp_frame); end
    tk(8, 1, 1'b0);
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL fr_ack_fall: got %b expected 0", frame_valid); end
    for (int i = 9; i < 16; i++) tk(i, 0, 1'b0);
    exp_frame = ramp(8);
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL fr_valid2: got %b expected 1", frame_valid); end
    checks++; if (frame_data !== exp_frame) begin errors++; $display("FAIL fr_frame1: got %h expected %h", frame_data, exp_frame); end
  endtask

  task automatic test_trigger();
    mode = 2'd1; ch_sel = 2'd0; sel_ch = 0; trig_level = 12'd100;
    do_reset();
    tk(150, 0, 1'b0);
    checks++; if (capturing !== 1'b0) begin errors++; $display("FAIL trig_first_tick: got %b expected 0", capturing); end
    tk(50, 0, 1'b0); tk(90, 0, 1'b0); tk(99, 0, 1'b0);
    checks++; if (capturing !== 1'b0) begin errors++; $display("FAIL trig_below: got %b expected 0", capturing); end
    tk(100, 0, 1'b0);
    checks++; if (capturing !== 1'b1) begin errors++; $display("FAIL trig_fire: got %b expected 1", capturing); end
    for (int i = 120; i < 127; i++) tk(i, 0, 1'b0);
    exp_frame = ramp(119);
    exp_frame[0 +: W] = 12'd100;
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL trig_valid: got %b expected 1", frame_valid); end
    checks++; if (frame_data !== exp_frame) begin errors++; $display("FAIL trig_frame: got %h expected %h", frame_data, exp_frame); end
    checks++; if (capturing !== 1'b0) begin errors++; $display("FAIL trig_rearm_wait: got %b expected 0", capturing); end
  endtask

  task automatic test_single_shot();
    mode = 2'd2; ch_sel = 2'd2; sel_ch = 2;
    do_reset();
    for (int i = 0; i < 100; i++) tk(500 + i, 0, 1'b0);
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL ss_no_arm_valid: got %b expected 0", frame_valid); end
    checks++; if (capturing !== 1'b0) begin errors++; $display("FAIL ss_no_arm_cap: got %b expected 0", capturing); end
    tk(10, 0, 1'b1);
    checks++; if (capturing !== 1'b1) begin errors++; $display("FAIL ss_armed: got %b expected 1", capturing); end
    for (int i = 11; i < 18; i++) tk(i, 0, (i == 13));
    exp_frame = ramp(10);
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL ss_valid: got %b expected 1", frame_valid); end
    checks++; if (frame_data !== exp_frame) begin errors++; $display("FAIL ss_frame: got %h expected %h", frame_data, exp_frame); end
    checks++; if (capturing !== 1'b0) begin errors++; $display("FAIL ss_idle: got %b expected 0", capturing); end
    for (int i = 0; i < 10; i++) tk(300 + i, 0, 1'b0);
    checks++; if (capturing !== 1'b0) begin errors++; $display("FAIL ss_stay_idle: got %b expected 0", capturing); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ss_overrun: got %b expected 0", overrun); end
  endtask

  task automatic test_back_pressure();
    mode = 2'd0; ch_sel = 2'd2; sel_ch = 2;
    do_reset();
    for (int i = 20; i < 28; i++) tk(i, 0, 1'b0);
    for (int i = 30; i < 38; i++) tk(i, 0, 1'b0);
    exp_frame = ramp(20);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL bp_overrun: got %b expected 1", overrun); end
    checks++; if (frame_data !== exp_frame) begin errors++; $display("FAIL bp_hold1: got %h expected %h", frame_data, exp_frame); end
    for (int i = 40; i < 48; i++) tk(i, 0, 1'b0);
    checks++; if (frame_data !== exp_frame) begin errors++; $display("FAIL bp_hold2: got %h expected %h", frame_data, exp_frame); end
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b expected 1", frame_valid); end
    tk(50, 1, 1'b0);
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL bp_ack_valid: got %b expected 0", frame_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL bp_ack_overrun: got %b expected 0", overrun); end
    for (int i = 51; i < 58; i++) tk(i, 0, 1'b0);
    exp_frame = ramp(50);
    checks++; if (frame_data !== exp_frame) begin errors++; $display("FAIL bp_next: got %h expected %h", frame_data, exp_frame); end
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL bp_next_valid: got %b expected 1", frame_valid); end
  endtask

  task automatic test_back_to_back();
    for (int i = 60; i < 67; i++) tk(i, 0, 1'b0);
    exp_frame = ramp(50);
    checks++; if (frame_data !== exp_frame) begin errors++; $display("FAIL b2b_before: got %h expected %h", frame_data, exp_frame); end
    tk(67, 2, 1'b0);
    exp_frame = ramp(60);
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b expected 1", frame_valid); end
    checks++; if (frame_data !== exp_frame) begin errors++; $display("FAIL b2b_frame: got %h expected %h", frame_data, exp_frame); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun: got %b expected 0", overrun); end
  endtask

  task automatic test_async_reset();
    tk(70, 0, 1'b0); tk(71, 0, 1'b0); tk(72, 0, 1'b0);
    @(posedge clock); #2;
    reset = 1'b0;
    #1;
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL ar_valid: got %b expected 0", frame_valid); end
    checks++; if (capturing !== 1'b0) begin errors++; $display("FAIL ar_capturing: got %b expected 0", capturing); end
    checks++; if (frame_data !== '0) begin errors++; $display("FAIL ar_data: got %h expected 0", frame_data); end
    @(posedge clock); #3;
    reset = 1'b1;
    tk(80, 0, 1'b0);
    checks++; if (capturing !== 1'b1) begin errors++; $display("FAIL ar_restart: got %b expected 1", capturing); end
    for (int i = 81; i < 87; i++) tk(i, 0, 1'b0);
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL ar_early: got %b expected 0", frame_valid); end
    tk(87, 0, 1'b0);
    exp_frame = ramp(80);
    checks++; if (frame_data !== exp_frame) begin errors++; $display("FAIL ar_frame: got %h expected %h", frame_data, exp_frame); end
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL ar_valid2: got %b expected 1", frame_valid); end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_trigger();
    test_single_shot();
    test_back_pressure();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sample_frame_capture.md
Name: sample_frame_capture

Overview:
- Parametrised multi-channel sample-frame capture stage that sits between the ADC channel outputs and the FFT input.
- Selects one of CHANNELS ADC channels and decimates it with an internal sample strobe.
- Captures frames of POINTS samples into a ping-pong (double) buffer.
- Hands each completed frame to the FFT with a valid/ack handshake. Supports free-run, level-triggered and single-shot capture, and flags dropped frames.

Parameters:
- POINTS, 64, samples per frame; power of two, 8..1024
- WIDTH, 12, ADC sample width in bits (unsigned)
- CHANNELS, 8, number of ADC channels on ch_data
- SAMPLE_DIV, 3150, clock cycles per sample strobe (25.2 MHz / 8 kHz); must be >= 2

Ports:
- clock  in  1  single system clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- ch_data  in  CHANNELS*WIDTH  packed ADC channels; channel k is bits [k*WIDTH +: WIDTH]
- ch_sel  in  max(1,$clog2(CHANNELS))  channel select; values >= CHANNELS select channel 0
- mode  in  2  0 = free-run, 1 = rising-level trigger, 2 = single-shot, 3 = treated as 0
- trig_level  in  WIDTH  trigger threshold, unsigned
- arm  in  1  single-shot start pulse
- frame_ack  in  1  consumer has taken the read bank
- frame_data  out  POINTS*WIDTH  read bank; sample n is bits [n*WIDTH +: WIDTH], n=0 is oldest
- frame_valid  out  1  read bank holds an unconsumed frame
- capturing  out  1  high while in FILL
- overrun  out  1  sticky; a completed frame was dropped

Behaviour:
- Reset (reset=0, asynchronous):
  - States: divider=0, write index=0, state IDLE.
  - Outputs: frame_valid=0, capturing=0, overrun=0, frame_data all zeros.
  - Both banks are cleared.
- Strobe: the divider counts 0..SAMPLE_DIV-1 and wraps. tick=1 on the cycle the count equals SAMPLE_DIV-1. The divider free-runs in every state.
- Sample: sample = ch_data[ch_lat*WIDTH +: WIDTH], registered on tick. ch_lat and mode_lat are latched when leaving IDLE or FILL.
- FSM states: IDLE, WAIT_TRIG, FILL.
  - IDLE:
    - mode 0/3 -> FILL on the next cycle.
    - mode 1 -> WAIT_TRIG.
    - mode 2 -> FILL only on the cycle after arm=1.
    - arm is ignored in every other state and mode.
  - WAIT_TRIG:
    - On each tick, compare prev < trig_level and cur >= trig_level.
    - prev is the sample from the previous tick. It is invalid on the first tick after entry, so no trigger can fire on that tick.
    - On trigger, write cur as index 0, go to FILL with index=1.
  - FILL:
    - Each tick writes the sample to write_bank[index] and increments index.
    - On the tick writing index POINTS-1, the frame is complete.
    - Next state: mode_lat 0 -> FILL with index 0; mode_lat 1 -> WAIT_TRIG; mode_lat 2 -> IDLE.
- Frame completion and handoff:
  - If frame_valid=0, or frame_ack=1 in the same cycle, swap banks. frame_valid is 1 on the next cycle and frame_data shows the new frame.
  - Otherwise the frame is dropped: the write bank is reused, the read bank is untouched, and overrun is set.
  - Latency: frame_valid rises 1 cycle after the final-sample tick.
- Handshake:
  - frame_valid stays high and frame_data holds stable until frame_ack=1 is sampled. frame_valid falls on the next cycle unless a swap happens in that same cycle.
  - frame_ack while frame_valid=0 is ignored.
  - overrun clears only on frame_ack=1 sampled while frame_valid=1, and only when no new drop occurs in that cycle. A drop takes priority.
- Mode or ch_sel changes mid-frame take effect only at the next frame boundary.
- Reset mid-FILL discards the partial frame. After release, capture restarts from IDLE with index 0.
- Widths: no arithmetic on samples; the trigger comparison is unsigned WIDTH-bit. Index width is $clog2(POINTS).

Test Plan:
- Free-run, SAMPLE_DIV=4, POINTS=8, ch_sel=2, ch_data channel 2 ramps +1 per tick from 0 -> frame_valid rises 1 cycle after the 8th tick, with frame_data = 0..7 (n=0 oldest); after ack, the next frame = 8..15.
- Level trigger, trig_level=100, channel 0 sequence 50,90,99,100,120,... -> frame index 0 = 100, index 1 = 120. Also drive a first-tick value of 150 with no valid prior sample -> no trigger fires.
- Single-shot mode 2, no arm -> frame_valid stays 0 for 100 ticks. Pulse arm -> exactly one frame is captured, then IDLE with capturing=0. A second arm mid-FILL has no effect.
- Back-pressure: never assert frame_ack over 2 frame times -> the first frame's data stays unchanged and overrun=1. Then ack -> frame_valid falls, overrun=0, and the next completed frame swaps in.
- Frame completion in the same cycle as frame_ack -> swap occurs, frame_valid stays 1 with new data, overrun stays 0.
- Assert reset=0 mid-FILL for 1 cycle, asynchronously between clock edges -> all outputs drop to 0 immediately. After release, the first frame starts from index 0 with no residual samples.
